pll_cfg_sequencer: RTL
======================

PLL_CFG_SEQUENCER -- requirements
Module: pll_cfg_sequencer

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, giving the number of clk_in cycles pll_rst_n is held low per attempt.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 65536, giving the clk_in cycles allowed per attempt to reach lock.
REQ-003 The block SHALL have parameter LOCK_STABLE, default 256, giving the consecutive lock cycles required before declaring lock.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3, giving the number of extra attempts allowed after the first timeout.
REQ-005 The block SHALL have clk_in, input, 1 bit: system clock.
REQ-006 The block SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have cfg_valid, input, 1 bit: configuration request.
REQ-008 The block SHALL have cfg_ready, output, 1 bit: request accepted when high together with cfg_valid.
REQ-009 The block SHALL have cfg_div, input, 32 bits: requested feedback divider.
REQ-010 The block SHALL have cfg_freq, input, 32 bits: requested initial NCO frequency word.
REQ-011 The block SHALL have pll_lock, input, 1 bit: raw PLL lock_detect, asynchronous to clk_in.
REQ-012 The block SHALL have pll_rst_n, output, 1 bit: PLL reset, active-low.
REQ-013 The block SHALL have div_val and initial_freq, both outputs, 32 bits each: registered settings driven to the PLL.
REQ-014 The block SHALL have locked, fail and busy, outputs, 1 bit each: status flags.
REQ-015 The block SHALL have retry_cnt, output, 4 bits: number of retries in the current sequence.

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchronizer (lock_s) before any use.
REQ-017 The state machine SHALL have the states IDLE, APPLY, WAIT_LOCK, STABLE, LOCKED and FAIL.
REQ-018 cfg_ready SHALL be 1 in IDLE, LOCKED and FAIL, and 0 in all other states.
REQ-019 A handshake SHALL be cfg_valid and cfg_ready both high on the same clk_in edge; cfg_valid while cfg_ready is 0 SHALL be ignored without being queued.
REQ-020 On a handshake in cycle N, the following SHALL take effect in cycle N+1:
- div_val and initial_freq latch cfg_div and cfg_freq.
- retry_cnt becomes 0.
- locked and fail become 0.
- The state becomes APPLY.
REQ-021 A handshake with cfg_div of 0 SHALL go to FAIL with fail=1 in cycle N+1, and div_val SHALL stay unchanged.
REQ-022 APPLY SHALL drive pll_rst_n=0 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with pll_rst_n=1.
REQ-023 Entering APPLY SHALL clear the timeout counter, and the counter SHALL increment every cycle in WAIT_LOCK and STABLE.
REQ-024 In WAIT_LOCK, lock_s=1 SHALL move the state to STABLE with the stable counter at 0.
REQ-025 In STABLE, lock_s=0 SHALL return the state to WAIT_LOCK; the timeout counter SHALL NOT be cleared.
REQ-026 In STABLE, after LOCK_STABLE consecutive cycles with lock_s=1, the state SHALL go to LOCKED with locked=1.
REQ-027 When the timeout counter reaches LOCK_TIMEOUT:
- If retry_cnt < MAX_RETRIES, retry_cnt SHALL increment and the state SHALL go to APPLY.
- Otherwise the state SHALL go to FAIL with fail=1.
REQ-028 If stable completion and timeout occur in the same cycle, stable completion SHALL take precedence.
REQ-029 busy SHALL be 1 in APPLY, WAIT_LOCK and STABLE.
REQ-030 In LOCKED, lock_s=0 SHALL be handled per REQ-034/REQ-035.
REQ-031 In LOCKED, a handshake in the same cycle as lock loss SHALL take precedence (REQ-020).
REQ-032 retry_cnt SHALL saturate at 15.

Reset
REQ-033 While rst_n=0, the block SHALL asynchronously hold:
- state IDLE
- pll_rst_n=0
- div_val=0 and initial_freq=0
- locked, fail and busy = 0
- retry_cnt=0
- cfg_ready=1
- synchronizer flops = 0
- all counters = 0
Reset deassertion mid-sequence SHALL restart from IDLE with no request pending.

Configuration
REQ-034 With PLL_SEQ_AUTO_RELOCK_EN defined, lock loss in LOCKED SHALL set locked=0, clear retry_cnt, and go to APPLY using the held div_val and initial_freq.
REQ-035 Without PLL_SEQ_AUTO_RELOCK_EN, lock loss in LOCKED SHALL set locked=0 and fail=1 and go to FAIL.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, MAX_RETRIES=2)
REQ-036 Handshake cfg_div=10, cfg_freq=429496730 with pll_lock tied high -> pll_rst_n low for 4 cycles, then locked=1 after sync plus 8 stable cycles, div_val=10.
REQ-037 pll_lock tied low -> APPLY entered 3 times, retry_cnt=2, then fail=1 about 3x(4+100) cycles after the handshake.
REQ-038 pll_lock toggled every 5 cycles -> never locked, ending in FAIL; cfg_valid during busy is ignored and div_val is unchanged.
REQ-039 Lock dropped while LOCKED -> with the macro, re-APPLY and relock; without it, fail=1.
REQ-040 cfg_div=0 -> fail=1 next cycle, pll_rst_n unchanged; rst_n asserted in WAIT_LOCK -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pll_cfg_sequencer.sv
// pll_cfg_sequencer
//   Accepts a PLL configuration request, drives the divider and initial NCO
//   frequency to the PLL, pulses the PLL reset, then waits for a stable lock.
//   Each attempt that times out is retried until the retry limit is reached.
//   After that the sequencer parks in FAIL.
//
// Ports
//   clk_in        system clock
//   rst_n         asynchronous active-low reset
//   cfg_valid     configuration request
//   cfg_ready     request accepted when high together with cfg_valid
//   cfg_div       requested feedback divider (0 is rejected)
//   cfg_freq      requested initial NCO frequency word
//   pll_lock      raw PLL lock_detect, asynchronous to clk_in
//   pll_rst_n     PLL reset, active-low
//   div_val       registered divider driven to the PLL
//   initial_freq  registered frequency word driven to the PLL
//   locked        PLL reached a stable lock
//   fail          request rejected, retries exhausted or lock lost
//   busy          a lock sequence is in progress
//   retry_cnt     retries used in the current sequence (saturates at 15)
//
// Build option
//   PLL_SEQ_AUTO_RELOCK_EN  when defined, lock loss in LOCKED restarts the
//                           sequence with the held settings instead of
//                           going to FAIL.
module pll_cfg_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRIES  = 3
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_div,
  input  logic [31:0] cfg_freq,
  input  logic        pll_lock,
  output logic        pll_rst_n,
  output logic [31:0] div_val,
  output logic [31:0] initial_freq,
  output logic        locked,
  output logic        fail,
  output logic        busy,
  output logic [3:0]  retry_cnt
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W  = $clog2(LOCK_STABLE + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(LOCK_STABLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT_LOCK,
    STABLE,
    LOCKED,
    FAIL
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic [RST_W-1:0] rst_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [ST_W-1:0]  stab_cnt;

  // Two-flop synchronizer: pll_lock comes from the PLL's own clock domain.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Sequencer FSM. cfg_ready is registered alongside the state, so it is
  // high exactly in IDLE, LOCKED and FAIL. A handshake is therefore only
  // possible in those states and always takes priority over lock loss.
  // Stable completion is tested before the timeout, so a lock that finishes
  // on the last cycle of the window still counts.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pll_rst_n    <= 1'b0;
      div_val      <= '0;
      initial_freq <= '0;
      locked       <= 1'b0;
      fail         <= 1'b0;
      busy         <= 1'b0;
      cfg_ready    <= 1'b1;
      retry_cnt    <= '0;
      rst_cnt      <= '0;
      to_cnt       <= '0;
      stab_cnt     <= '0;
    end else if (cfg_valid && cfg_ready) begin
      retry_cnt <= '0;
      locked    <= 1'b0;
      if (cfg_div == 32'd0) begin
        state     <= FAIL;
        fail      <= 1'b1;
        busy      <= 1'b0;
        cfg_ready <= 1'b1;
      end else begin
        div_val      <= cfg_div;
        initial_freq <= cfg_freq;
        fail         <= 1'b0;
        state        <= APPLY;
        pll_rst_n    <= 1'b0;
        busy         <= 1'b1;
        cfg_ready    <= 1'b0;
        rst_cnt      <= '0;
        to_cnt       <= '0;
      end
    end else if (state == STABLE && lock_s && stab_cnt == ST_LAST) begin
      state     <= LOCKED;
      locked    <= 1'b1;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else if ((state == WAIT_LOCK || state == STABLE) && to_cnt == TO_LAST) begin
      if (int'({28'd0, retry_cnt}) < MAX_RETRIES) begin
        retry_cnt <= (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
        state     <= APPLY;
        pll_rst_n <= 1'b0;
        rst_cnt   <= '0;
        to_cnt    <= '0;
      end else begin
        state     <= FAIL;
        fail      <= 1'b1;
        busy      <= 1'b0;
        cfg_ready <= 1'b1;
      end
    end else begin
      case (state)
        APPLY: begin
          if (rst_cnt == RST_LAST) begin
            state     <= WAIT_LOCK;
            pll_rst_n <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          to_cnt <= to_cnt + 1'b1;
          if (lock_s) begin
            state    <= STABLE;
            stab_cnt <= '0;
          end
        end
        STABLE: begin
          to_cnt <= to_cnt + 1'b1;
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (!lock_s) begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            locked    <= 1'b0;
            retry_cnt <= '0;
            state     <= APPLY;
            pll_rst_n <= 1'b0;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            rst_cnt   <= '0;
            to_cnt    <= '0;
`else
            locked <= 1'b0;
            fail   <= 1'b1;
            state  <= FAIL;
`endif
          end
        end
        IDLE, FAIL: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
